// File: rtl/simon_seq_ctrl.sv
// Simon Says game sequencer: grows a random colour sequence, plays it on one-hot LEDs and
// checks the player's presses. Define INPUT_TIMEOUT_EN to add the per-press input timeout.
module simon_seq_ctrl #(
    parameter int MAX_LEN       = 32,
    parameter int TICKS_ON      = 50_000_000,
    parameter int TICKS_OFF     = 25_000_000,
    parameter int TIMEOUT_TICKS = 500_000_000,
    parameter int LW            = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [3:0]    RAND,
    input  logic          BTN_VALID,
    input  logic [1:0]    BTN_ID,
    output logic [3:0]    LED,
    output logic [LW-1:0] LEVEL,
    output logic          BUSY,
    output logic          TURN,
    output logic          WIN,
    output logic          LOSE,
    output logic [2:0]    dbg_state
);

    localparam int TMAX_A = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
    localparam int TMAX   = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(TICKS_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(TICKS_OFF - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WON, LOST
    } state_t;

    state_t        state;
    logic [LW-1:0] idx;
    logic [TW-1:0] timer;
    logic [1:0]    seq [0:(1 << IW) - 1];

    logic [LW-1:0] idx_nxt;
    logic [LW-1:0] level_last;
    logic [1:0]    first_color;
    logic          unused_rand;

    assign idx_nxt     = idx + 1'b1;
    assign level_last  = LEVEL - 1'b1;
    // In ADD the first step may be the entry being written this very cycle.
    assign first_color = (LEVEL == '0) ? RAND[1:0] : seq[0];
    assign unused_rand = ^RAND[3:2];
    assign dbg_state   = state;

    // Sequence storage is deliberately not reset; only written in ADD.
    always_ff @(posedge CLK) begin
        if (state == ADD) begin
            seq[LEVEL[IW-1:0]] <= RAND[1:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            LED   <= '0;
            LEVEL <= '0;
            BUSY  <= 1'b0;
            TURN  <= 1'b0;
            WIN   <= 1'b0;
            LOSE  <= 1'b0;
            idx   <= '0;
            timer <= '0;
        end else begin
            case (state)
                IDLE, WON, LOST: begin
                    if (START) begin
                        state <= ADD;
                        LEVEL <= '0;
                        BUSY  <= 1'b1;
                        WIN   <= 1'b0;
                        LOSE  <= 1'b0;
                    end
                end
                ADD: begin
                    LEVEL <= LEVEL + 1'b1;
                    idx   <= '0;
                    timer <= '0;
                    LED   <= 4'b0001 << first_color;
                    state <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (timer == ON_LAST) begin
                        timer <= '0;
                        LED   <= '0;
                        state <= SHOW_OFF;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SHOW_OFF: begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        if (idx == level_last) begin
                            idx   <= '0;
                            BUSY  <= 1'b0;
                            TURN  <= 1'b1;
                            state <= WAIT_IN;
                        end else begin
                            idx   <= idx_nxt;
                            LED   <= 4'b0001 << seq[idx_nxt[IW-1:0]];
                            state <= SHOW_ON;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_IN: begin
                    // A press always wins over START and over an expiring timeout.
                    if (BTN_VALID) begin
                        timer <= '0;
                        if (BTN_ID != seq[idx[IW-1:0]]) begin
                            TURN  <= 1'b0;
                            LOSE  <= 1'b1;
                            state <= LOST;
                        end else if (idx != level_last) begin
                            idx <= idx_nxt;
                        end else if (LEVEL == LEN_MAX) begin
                            TURN  <= 1'b0;
                            WIN   <= 1'b1;
                            state <= WON;
                        end else begin
                            TURN  <= 1'b0;
                            BUSY  <= 1'b1;
                            state <= ADD;
                        end
                    end
`ifdef INPUT_TIMEOUT_EN
                    else if (timer == TW'(TIMEOUT_TICKS - 1)) begin
                        TURN  <= 1'b0;
                        LOSE  <= 1'b1;
                        state <= LOST;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    LED   <= '0;
                    BUSY  <= 1'b0;
                    TURN  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Directed bench for simon_seq_ctrl with short timing: a vector table for the first rounds,
// then hand-written sequences for win, restart latency, async reset and input timeout.
module tb_simon_seq_ctrl;

    localparam int LW = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [3:0]    RAND;
    logic          BTN_VALID;
    logic [1:0]    BTN_ID;
    logic [3:0]    LED;
    logic [LW-1:0] LEVEL;
    logic          BUSY, TURN, WIN, LOSE;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    typedef struct packed {
        logic       start;
        logic [3:0] rnd;
        logic       bv;
        logic [1:0] bid;
        logic [9:0] exp_out;   // {LED, LEVEL, BUSY, TURN, WIN, LOSE}
    } vec_t;

    vec_t tbl [27];

    simon_seq_ctrl #(
        .MAX_LEN(3), .TICKS_ON(4), .TICKS_OFF(2), .TIMEOUT_TICKS(10)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .RAND(RAND),
        .BTN_VALID(BTN_VALID), .BTN_ID(BTN_ID), .LED(LED), .LEVEL(LEVEL),
        .BUSY(BUSY), .TURN(TURN), .WIN(WIN), .LOSE(LOSE), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic st, input logic [3:0] rnd, input logic bv,
                                input logic [1:0] bid, input logic [3:0] led,
                                input logic [1:0] lvl, input logic busy, input logic turn,
                                input logic win, input logic lose);
        vec_t v;
        v.start   = st;
        v.rnd     = rnd;
        v.bv      = bv;
        v.bid     = bid;
        v.exp_out = {led, lvl, busy, turn, win, lose};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [1:0] id, input logic [3:0] rnd, input logic st);
        BTN_VALID = 1'b1;
        BTN_ID    = id;
        RAND      = rnd;
        START     = st;
        tick();
        BTN_VALID = 1'b0;
        START     = 1'b0;
    endtask

    // Scoreboard on playback: every lit step must match the next queued colour and last 4 cycles.
    task automatic wait_turn(input string tag);
        logic [3:0] prev;
        int run;
        int n;
        bit done;
        prev = '0;
        run  = 0;
        n    = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            if (TURN) begin
                done = 1'b1;
            end else begin
                if (LED != 4'b0000) begin
                    if (prev == 4'b0000) begin
                        if (exp_q.size() == 0) chk({tag, " extra_step"}, LED, 0);
                        else chk({tag, " colour"}, LED, exp_q.pop_front());
                        run = 0;
                    end
                    run++;
                end else if (prev != 4'b0000) begin
                    chk({tag, " on_len"}, run, 4);
                end
                prev = LED;
                tick();
                n++;
            end
        end
        chk({tag, " reached_turn"}, done, 1);
        chk({tag, " all_shown"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; RAND = '0; BTN_VALID = 1'b0; BTN_ID = '0;
        #12;
        RST = 1'b0;
        chk("reset_state", {LED, LEVEL, BUSY, TURN, WIN, LOSE}, 0);

        //            st  rnd   bv bid  led      lvl busy turn win lose
        tbl[0]  = mk(1, 4'hE, 0, 0, 4'b0000, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 4'hE, 0, 0, 4'b0100, 1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 4'hE, 0, 0, 4'b0100, 1, 1, 0, 0, 0);
        tbl[3]  = mk(1, 4'hE, 1, 1, 4'b0100, 1, 1, 0, 0, 0);
        tbl[4]  = mk(0, 4'hE, 0, 0, 4'b0100, 1, 1, 0, 0, 0);
        tbl[5]  = mk(0, 4'hE, 0, 0, 4'b0000, 1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 4'hE, 0, 0, 4'b0000, 1, 1, 0, 0, 0);
        tbl[7]  = mk(0, 4'hE, 0, 0, 4'b0000, 1, 0, 1, 0, 0);
        tbl[8]  = mk(0, 4'h5, 1, 2, 4'b0000, 1, 1, 0, 0, 0);
        tbl[9]  = mk(0, 4'h5, 0, 0, 4'b0100, 2, 1, 0, 0, 0);
        tbl[10] = mk(0, 4'h5, 0, 0, 4'b0100, 2, 1, 0, 0, 0);
        tbl[11] = mk(0, 4'h5, 0, 0, 4'b0100, 2, 1, 0, 0, 0);
        tbl[12] = mk(0, 4'h5, 0, 0, 4'b0100, 2, 1, 0, 0, 0);
        tbl[13] = mk(0, 4'h5, 0, 0, 4'b0000, 2, 1, 0, 0, 0);
        tbl[14] = mk(0, 4'h5, 0, 0, 4'b0000, 2, 1, 0, 0, 0);
        tbl[15] = mk(0, 4'h5, 0, 0, 4'b0010, 2, 1, 0, 0, 0);
        tbl[16] = mk(0, 4'h5, 0, 0, 4'b0010, 2, 1, 0, 0, 0);
        tbl[17] = mk(0, 4'h5, 0, 0, 4'b0010, 2, 1, 0, 0, 0);
        tbl[18] = mk(0, 4'h5, 0, 0, 4'b0010, 2, 1, 0, 0, 0);
        tbl[19] = mk(0, 4'h5, 0, 0, 4'b0000, 2, 1, 0, 0, 0);
        tbl[20] = mk(0, 4'h5, 0, 0, 4'b0000, 2, 1, 0, 0, 0);
        tbl[21] = mk(0, 4'h5, 0, 0, 4'b0000, 2, 0, 1, 0, 0);
        tbl[22] = mk(0, 4'h5, 1, 2, 4'b0000, 2, 0, 1, 0, 0);
        tbl[23] = mk(0, 4'h5, 1, 3, 4'b0000, 2, 0, 0, 0, 1);
        tbl[24] = mk(0, 4'h5, 1, 1, 4'b0000, 2, 0, 0, 0, 1);
        tbl[25] = mk(1, 4'hF, 0, 0, 4'b0000, 0, 1, 0, 0, 0);
        tbl[26] = mk(0, 4'hF, 0, 0, 4'b1000, 1, 1, 0, 0, 0);

        for (int i = 0; i < 27; i++) begin
            START     = tbl[i].start;
            RAND      = tbl[i].rnd;
            BTN_VALID = tbl[i].bv;
            BTN_ID    = tbl[i].bid;
            tick();
            chk($sformatf("vec%0d", i), {LED, LEVEL, BUSY, TURN, WIN, LOSE}, tbl[i].exp_out);
        end
        START = 1'b0; BTN_VALID = 1'b0;

        // Full game to WIN: sequence becomes 3, 0, 1.
        exp_q.push_back(4'b1000);
        wait_turn("r1");
        press(2'd3, 4'h4, 1'b0);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        wait_turn("r2");
        press(2'd3, 4'h4, 1'b0);
        press(2'd0, 4'h9, 1'b0);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        wait_turn("r3");
        press(2'd3, 4'h9, 1'b1);
        chk("start_ignored_in_turn", {TURN, BUSY, WIN, LEVEL}, {1'b1, 1'b0, 1'b0, 2'd3});
        press(2'd0, 4'h9, 1'b0);
        press(2'd1, 4'h9, 1'b1);
        chk("win", {LED, LEVEL, BUSY, TURN, WIN, LOSE}, {4'b0000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0});
        press(2'd2, 4'h9, 1'b0);
        chk("win_held", {LED, LEVEL, BUSY, TURN, WIN, LOSE}, {4'b0000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0});

        // Restart from WIN: ADD next cycle, first LED two cycles after START.
        START = 1'b1; RAND = 4'h6;
        tick();
        START = 1'b0;
        chk("restart_add", {BUSY, WIN, LED, LEVEL}, {1'b1, 1'b0, 4'b0000, 2'd0});
        tick();
        chk("restart_lit", {LED, LEVEL, BUSY}, {4'b0100, 2'd1, 1'b1});
        tick();

        // Asynchronous reset between clock edges, mid SHOW_ON.
        #3 RST = 1'b1;
        #1 chk("async_reset", {LED, LEVEL, BUSY, TURN, WIN, LOSE}, 0);
        #2 RST = 1'b0;
        tick();
        chk("idle_after_reset", {LED, LEVEL, BUSY, TURN, WIN, LOSE}, 0);

        START = 1'b1; RAND = 4'h0;
        tick();
        START = 1'b0;
        exp_q.push_back(4'b0001);
        wait_turn("r_to");
`ifdef INPUT_TIMEOUT_EN
        repeat (9) tick();
        chk("before_timeout", {TURN, LOSE}, {1'b1, 1'b0});
        tick();
        chk("timeout_lose", {TURN, LOSE, LEVEL}, {1'b0, 1'b1, 2'd1});
`else
        repeat (100) tick();
        chk("no_timeout", {TURN, LOSE, BUSY}, {1'b1, 1'b0, 1'b0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
